// File: rtl/series_controller_pkg.sv
// Shared encodings for the series-approximation controller: ALU opcodes, FSM
// states, operand/write-enable codes and the state-to-control decode.
package series_ctrl_pkg;

    localparam logic [2:0] OP_ADD_ONE  = 3'd0;
    localparam logic [2:0] OP_SUB_ONE  = 3'd1;
    localparam logic [2:0] OP_ADD_SUB  = 3'd2;
    localparam logic [2:0] OP_MULTIPLY = 3'd3;
    localparam logic [2:0] OP_ALU_IDLE = 3'd4;
    localparam logic [2:0] OP_PASS_A   = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PREP,
        S_WB,
        S_ACC,
        S_INC,
        S_MULT,
        S_WB2,
        S_CHECK,
        S_DONE
    } state_e;

    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_X    = 3'd1;
    localparam logic [2:0] SRC_Y    = 3'd2;
    localparam logic [2:0] SRC_X1   = 3'd3;
    localparam logic [2:0] SRC_N    = 3'd4;

    localparam int WR_X1        = 0;
    localparam int WR_X1_N      = 1;
    localparam int WR_X1_N_MULT = 2;
    localparam int WR_Y         = 3;
    localparam int WR_N         = 4;
    localparam int WR_SIGMA     = 5;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_CONV  = 2'd1;
    localparam logic [1:0] CAUSE_LIMIT = 2'd2;
    localparam logic [1:0] CAUSE_ABORT = 2'd3;

    localparam logic MODE_LN  = 1'b0;
    localparam logic MODE_EXP = 1'b1;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] alu_op;
        logic [2:0] src_a;
        logic       x1_n_to_alu_b;
        logic       sigma_to_alu;
        logic [5:0] wren;
        logic       check;
    } ctrl_t;

    // Moore decode; first_mult marks the cycle that latches n and sigma.
    function automatic ctrl_t ctrl_decode(input state_e st, input logic mode,
                                          input logic first_mult);
        ctrl_t c;
        c        = '0;
        c.alu_op = OP_ALU_IDLE;
        c.busy   = (st != S_IDLE);
        case (st)
            S_PREP: begin
                c.src_a  = SRC_X;
                c.alu_op = (mode == MODE_EXP) ? OP_PASS_A : OP_SUB_ONE;
            end
            S_WB: begin
                c.wren[WR_X1]   = 1'b1;
                c.wren[WR_X1_N] = 1'b1;
            end
            S_ACC: begin
                c.src_a         = SRC_Y;
                c.x1_n_to_alu_b = 1'b1;
                c.sigma_to_alu  = (mode == MODE_LN);
                c.alu_op        = OP_ADD_SUB;
            end
            S_INC: begin
                c.src_a      = SRC_N;
                c.alu_op     = OP_ADD_ONE;
                c.wren[WR_Y] = 1'b1;
            end
            S_MULT: begin
                c.src_a          = SRC_X1;
                c.x1_n_to_alu_b  = 1'b1;
                c.alu_op         = OP_MULTIPLY;
                c.wren[WR_N]     = first_mult;
                c.wren[WR_SIGMA] = first_mult && (mode == MODE_LN);
            end
            S_WB2:   c.wren[WR_X1_N_MULT] = 1'b1;
            S_CHECK: c.check = 1'b1;
            S_DONE:  c.done  = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/series_controller.sv
// Sequencer for the shared ALU/register file computing ln(x) or exp(x) by
// series expansion, with iteration limit, convergence and abort termination.
module series_controller
    import series_ctrl_pkg::*;
#(
    parameter int ITER_W      = 8,
    parameter int MULT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              mode_i,
    input  logic [ITER_W-1:0] max_iter_i,
    input  logic              converged_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        term_cause_o,
    output logic [ITER_W-1:0] iter_o,
    output logic [2:0]        alu_op_o,
    output logic [2:0]        src_a_o,
    output logic              x1_n_to_alu_b_o,
    output logic              sigma_to_alu_o,
    output logic [5:0]        wren_o,
    output logic              check_for_termination_o
);

    localparam int                WAIT_W    = $clog2(MULT_CYCLES) + 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MULT_CYCLES - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = '1;

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ITER_W-1:0] max_iter_q, max_iter_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [1:0]        cause_q, cause_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    ctrl_t             ctrl_q, ctrl_d;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        max_iter_d = max_iter_q;
        iter_d     = iter_q;
        cause_d    = cause_q;
        wait_d     = wait_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d     = mode_i;
                    max_iter_d = max_iter_i;
                    iter_d     = '0;
                    cause_d    = CAUSE_NONE;
                    state_d    = S_PREP;
                end
            end
            S_PREP: state_d = S_WB;
            S_WB:   state_d = S_ACC;
            S_ACC:  state_d = S_INC;
            S_INC: begin
                wait_d  = WAIT_INIT;
                state_d = S_MULT;
            end
            S_MULT: begin
                if (wait_q == '0) begin
                    state_d = S_WB2;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_WB2: begin
                if (iter_q != ITER_MAX) begin
                    iter_d = iter_q + ITER_W'(1);
                end
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (converged_i) begin
                    cause_d = CAUSE_CONV;
                    state_d = S_DONE;
                end else if ((max_iter_q != '0) && (iter_q == max_iter_q)) begin
                    cause_d = CAUSE_LIMIT;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every other exit, but only while a run is active.
        if (abort_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            state_d = S_DONE;
            cause_d = CAUSE_ABORT;
        end

        // Outputs are decoded from the next state so the registered copy
        // lines up with the state it describes.
        ctrl_d = ctrl_decode(state_d, mode_d, wait_d == WAIT_INIT);
    end

    always_ff @(posedge clk) begin
        mode_q     <= mode_d;
        max_iter_q <= max_iter_d;
        if (rst) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            cause_q <= CAUSE_NONE;
            wait_q  <= '0;
            ctrl_q  <= ctrl_decode(S_IDLE, MODE_LN, 1'b0);
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign busy_o                  = ctrl_q.busy;
    assign done_o                  = ctrl_q.done;
    assign alu_op_o                = ctrl_q.alu_op;
    assign src_a_o                 = ctrl_q.src_a;
    assign x1_n_to_alu_b_o         = ctrl_q.x1_n_to_alu_b;
    assign sigma_to_alu_o          = ctrl_q.sigma_to_alu;
    assign wren_o                  = ctrl_q.wren;
    assign check_for_termination_o = ctrl_q.check;
    assign term_cause_o            = cause_q;
    assign iter_o                  = iter_q;

endmodule
